// File: rtl/mc_shift_register_fifo_pkg.sv
// ---------------------------------------------------------------------------
// mc_srfifo_pkg
//   Shared definitions for the multi-channel shift-register FIFO.
//   - count_width(): number of bits needed to hold an occupancy of 0..depth.
//   - ERR_* constants: bit positions of the two sticky error flags inside a
//     channel's packed error vector.
// ---------------------------------------------------------------------------
package mc_srfifo_pkg;

    localparam int ERR_OVERFLOW  = 0;
    localparam int ERR_UNDERFLOW = 1;
    localparam int ERR_BITS      = 2;

    // Occupancy ranges over 0..depth inclusive, hence depth+1 distinct values.
    function automatic int count_width(input int depth);
        return (depth < 1) ? 1 : $clog2(depth + 1);
    endfunction

endpackage : mc_srfifo_pkg

// File: rtl/mc_shift_register_fifo_channel.sv
// ---------------------------------------------------------------------------
// srfifo_channel
//   One shift-register FIFO channel. Slot 0 always holds the oldest entry and
//   drives data_out directly, so a read is a plain shift-down of the array.
//
// Ports
//   clk           in   sole clock, rising edge
//   rst           in   synchronous active-high reset
//   push          in   write request
//   pop           in   read request
//   data_in       in   [WIDTH]  write data
//   data_out      out  [WIDTH]  head entry (slot 0), combinational from storage
//   empty         out  count == 0
//   full          out  count == DEPTH
//   almost_empty  out  count <= AEMPTY_THRESH
//   almost_full   out  count >= AFULL_THRESH
//   count         out  [CW]     occupancy
//   overflow      out  sticky: push dropped because channel was full
//   underflow     out  sticky: pop ignored because channel was empty
//
// Request semantics: push/pop are single-cycle requests with no ready signal.
//   A pop is accepted when count > 0. A push is accepted when count < DEPTH,
//   or when count == DEPTH and a pop is accepted on the same edge (the pop
//   frees the slot the push fills). Rejected requests set the sticky flags.
// ---------------------------------------------------------------------------
module srfifo_channel
    import mc_srfifo_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 4,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  logic                          pop,
    input  logic [WIDTH-1:0]              data_in,
    output logic [WIDTH-1:0]              data_out,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          overflow,
    output logic                          underflow
);

    localparam int CW = count_width(DEPTH);

    // Thresholds recast to the counter width so comparisons are width-exact.
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_C   = CW'(AFULL_THRESH);
    localparam logic [CW-1:0] AEMPTY_C  = CW'(AEMPTY_THRESH);
    localparam logic [CW-1:0] ONE_C     = CW'(1);

    logic [WIDTH-1:0]    slot_q [DEPTH];
    logic [WIDTH-1:0]    slot_d [DEPTH];
    logic [CW-1:0]       count_q, count_d;
    logic [ERR_BITS-1:0] err_q, err_d;

    logic                is_empty, is_full;
    logic                pop_ok, push_ok;
    logic [CW-1:0]       wr_idx;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DEPTH_C);

    // A pop on a full channel makes room for a same-edge push.
    assign pop_ok   = pop && !is_empty;
    assign push_ok  = push && (!is_full || pop_ok);

    // With a concurrent pop everything moves down one, so the free slot is
    // one lower than the current occupancy.
    assign wr_idx   = pop_ok ? (count_q - ONE_C) : count_q;

    // ---------------------------------------------------------------
    // Storage next state
    // ---------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_d[i] = slot_q[i];
        end
        if (pop_ok) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                slot_d[i] = slot_q[i + 1];
            end
        end
        if (push_ok) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx == CW'(i)) begin
                    slot_d[i] = data_in;
                end
            end
        end
    end

    // ---------------------------------------------------------------
    // Occupancy and sticky error next state
    // ---------------------------------------------------------------
    always_comb begin
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + ONE_C;
            2'b01:   count_d = count_q - ONE_C;
            default: count_d = count_q;
        endcase

        err_d = err_q;
        if (push && is_full && !pop) begin
            err_d[ERR_OVERFLOW] = 1'b1;
        end
        if (pop && is_empty) begin
            err_d[ERR_UNDERFLOW] = 1'b1;
        end
    end

    // Slot contents are not reset: with count forced to zero they are never
    // observable as valid data, and a reset write-through would be wasted.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_q[i] <= slot_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            err_q   <= '0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    // ---------------------------------------------------------------
    // Outputs: all status derived from registered state only
    // ---------------------------------------------------------------
    assign data_out     = slot_q[0];
    assign count        = count_q;
    assign empty        = is_empty;
    assign full         = is_full;
    assign almost_empty = (count_q <= AEMPTY_C);
    assign almost_full  = (count_q >= AFULL_C);
    assign overflow     = err_q[ERR_OVERFLOW];
    assign underflow    = err_q[ERR_UNDERFLOW];

`ifdef FORMAL
    // Invariants a data-integrity proof relies on.
    always_comb begin
        assert (count_q <= DEPTH_C);
        assert (!(empty && full));
        if (!rst && push && pop && is_full) begin
            assert (push_ok && pop_ok);
        end
    end

    // Single-entry tracker: once a word is accepted while tracking is idle,
    // it must reach slot 0 after exactly the number of pops of the entries
    // ahead of it, and then appear unchanged on data_out.
    logic [CW-1:0]    trk_pos_q;
    logic             trk_vld_q;
    logic [WIDTH-1:0] trk_dat_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            trk_vld_q <= 1'b0;
            trk_pos_q <= '0;
            trk_dat_q <= '0;
        end else if (!trk_vld_q) begin
            if (push_ok) begin
                trk_vld_q <= 1'b1;
                trk_pos_q <= wr_idx;
                trk_dat_q <= data_in;
            end
        end else if (pop_ok) begin
            if (trk_pos_q == '0) begin
                trk_vld_q <= 1'b0;
            end else begin
                trk_pos_q <= trk_pos_q - ONE_C;
            end
        end
    end

    always_comb begin
        if (!rst && trk_vld_q && trk_pos_q == '0) begin
            assert (data_out == trk_dat_q);
        end
        if (!rst && trk_vld_q) begin
            assert (trk_pos_q < count_q);
        end
    end
`endif

endmodule : srfifo_channel

// File: rtl/mc_shift_register_fifo.sv
// ---------------------------------------------------------------------------
// mc_shift_register_fifo
//   CHANNELS fully independent shift-register FIFOs sharing one clock and
//   reset. Per-channel buses are packed with channel c at [c*W +: W].
//
// Ports
//   clk           in   sole clock, rising edge
//   rst           in   synchronous active-high reset
//   push          in   [CHANNELS]        write requests
//   pop           in   [CHANNELS]        read requests
//   data_in       in   [CHANNELS*WIDTH]  write data
//   data_out      out  [CHANNELS*WIDTH]  head entries
//   empty         out  [CHANNELS]
//   full          out  [CHANNELS]
//   almost_empty  out  [CHANNELS]        count <= AEMPTY_THRESH
//   almost_full   out  [CHANNELS]        count >= AFULL_THRESH
//   count         out  [CHANNELS*CW]     occupancy, CW = $clog2(DEPTH+1)
//   overflow      out  [CHANNELS]        sticky until rst
//   underflow     out  [CHANNELS]        sticky until rst
// ---------------------------------------------------------------------------
module mc_shift_register_fifo
    import mc_srfifo_pkg::*;
#(
    parameter int WIDTH         = 8,
    parameter int DEPTH         = 4,
    parameter int CHANNELS      = 2,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [CHANNELS-1:0]                    push,
    input  logic [CHANNELS-1:0]                    pop,
    input  logic [CHANNELS*WIDTH-1:0]              data_in,
    output logic [CHANNELS*WIDTH-1:0]              data_out,
    output logic [CHANNELS-1:0]                    empty,
    output logic [CHANNELS-1:0]                    full,
    output logic [CHANNELS-1:0]                    almost_empty,
    output logic [CHANNELS-1:0]                    almost_full,
    output logic [CHANNELS*count_width(DEPTH)-1:0] count,
    output logic [CHANNELS-1:0]                    overflow,
    output logic [CHANNELS-1:0]                    underflow
);

    localparam int CW = count_width(DEPTH);

`ifdef FORMAL
    if (DEPTH < 2) begin : g_bad_depth
        $error("mc_shift_register_fifo: DEPTH must be at least 2");
    end
    if (AFULL_THRESH > DEPTH || AFULL_THRESH < 0) begin : g_bad_afull
        $error("mc_shift_register_fifo: AFULL_THRESH must be within 0..DEPTH");
    end
    if (AEMPTY_THRESH > DEPTH || AEMPTY_THRESH < 0) begin : g_bad_aempty
        $error("mc_shift_register_fifo: AEMPTY_THRESH must be within 0..DEPTH");
    end
    if (WIDTH < 1 || CHANNELS < 1) begin : g_bad_shape
        $error("mc_shift_register_fifo: WIDTH and CHANNELS must be at least 1");
    end
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        srfifo_channel #(
            .WIDTH         (WIDTH),
            .DEPTH         (DEPTH),
            .AFULL_THRESH  (AFULL_THRESH),
            .AEMPTY_THRESH (AEMPTY_THRESH)
        ) u_channel (
            .clk          (clk),
            .rst          (rst),
            .push         (push[c]),
            .pop          (pop[c]),
            .data_in      (data_in[c*WIDTH +: WIDTH]),
            .data_out     (data_out[c*WIDTH +: WIDTH]),
            .empty        (empty[c]),
            .full         (full[c]),
            .almost_empty (almost_empty[c]),
            .almost_full  (almost_full[c]),
            .count        (count[c*CW +: CW]),
            .overflow     (overflow[c]),
            .underflow    (underflow[c])
        );
    end

endmodule : mc_shift_register_fifo

// File: doc/mc_shift_register_fifo.md
MC_SHIFT_REGISTER_FIFO -- requirements
Module: mc_shift_register_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits (>=1).
REQ-002 Parameter DEPTH, default 4, entries per channel (>=2).
REQ-003 Parameter CHANNELS, default 2, independent FIFO channels (>=1).
REQ-004 Parameter AFULL_THRESH, default DEPTH-1, almost_full asserts when count >= AFULL_THRESH.
REQ-005 Parameter AEMPTY_THRESH, default 1, almost_empty asserts when count <= AEMPTY_THRESH.
REQ-006 Clocking is fixed: one clock; reset is synchronous and active-high.
REQ-007 clk  input  1  sole clock; all state updates on rising edge.
REQ-008 rst  input  1  synchronous, active-high reset.
REQ-009 push  input  CHANNELS  per-channel write request.
REQ-010 pop  input  CHANNELS  per-channel read request.
REQ-011 data_in  input  CHANNELS*WIDTH  per-channel write data; channel c occupies bits [c*WIDTH +: WIDTH].
REQ-012 data_out  output  CHANNELS*WIDTH  per-channel head entry, same packing as data_in.
REQ-013 empty, full, almost_empty, almost_full  output  CHANNELS each  per-channel status flags.
REQ-014 count  output  CHANNELS*CW  per-channel occupancy, CW = $clog2(DEPTH+1).
REQ-015 overflow, underflow  output  CHANNELS each  sticky per-channel error flags.

Function
REQ-016 Each channel SHALL be a shift-register FIFO: slot 0 holds the oldest entry; data_out[c] SHALL equal slot 0 combinationally.
REQ-017 Channels SHALL be fully independent; no activity on one channel affects another.
REQ-018 Accepted pop SHALL shift all slots down by one at the clock edge; vacated top slot is don't-care.
REQ-019 Accepted push SHALL write data_in to slot count, or to slot count-1 when a pop is accepted on the same edge.
REQ-020 Push into an empty channel SHALL appear on data_out one cycle later (latency 1); no same-cycle bypass.
REQ-021 Push and pop on the same cycle with 0 < count < DEPTH: both accepted, count unchanged.
REQ-022 Push and pop when full: both accepted, count stays DEPTH, no overflow.
REQ-023 Push when full without pop: dropped, storage and count unchanged, overflow[c] set.
REQ-024 Pop when empty (with or without push): pop ignored, underflow[c] set; a concurrent push is still accepted.
REQ-025 count SHALL never exceed DEPTH nor wrap below 0; empty = (count==0), full = (count==DEPTH).
REQ-026 overflow/underflow SHALL remain set until rst; no other clear mechanism.
REQ-027 Flags SHALL be derived from registered count only (no combinational path from push/pop).

Reset
REQ-028 On rst=1 at a rising edge: count=0, empty=1, full=0, almost_empty=1, almost_full=(AFULL_THRESH==0), overflow=0, underflow=0, for all channels.
REQ-029 Push/pop presented in a reset cycle SHALL be ignored and SHALL NOT set error flags.
REQ-030 Reset mid-operation SHALL discard all stored entries; slot contents need not be cleared.

Structure
REQ-031 Package mc_srfifo_pkg SHALL hold the count-width helper function and error-flag index constants.
REQ-032 One sub-module, srfifo_channel (single-channel storage, count, flags), SHALL be instantiated CHANNELS times via generate.
REQ-033 Parameter legality (DEPTH>=2, thresholds <= DEPTH) SHALL be checked at elaboration under FORMAL.

Verification (WIDTH=8, DEPTH=4, CHANNELS=2)
REQ-034 Push 0x11,0x22,0x33,0x44 on ch0 -> full[0]=1, count[0]=4, almost_full[0]=1 after 3rd push; ch1 empty throughout.
REQ-035 Full ch0, push 0x55 without pop -> overflow[0]=1, then 4 pops return 0x11,0x22,0x33,0x44 in order.
REQ-036 Full ch0, push 0x55 with pop -> data_out[0]=0x22 next cycle, count stays 4, overflow[0]=0; 0x55 is 4th out.
REQ-037 Pop empty ch1 with push 0xA5 -> underflow[1]=1, count[1]=1, data_out[1]=0xA5 next cycle.
REQ-038 Load ch0 with 3 entries, assert rst one cycle -> count=0, empty=1, flags cleared; next push 0x77 is head.
REQ-039 Formal harness: scoreboard per channel proves data integrity under arbitrary push/pop, including errored requests.
